// File: rtl/noc_flit_pkg.sv
// rtl/noc_flit_pkg.sv - shared flit field layout, sink error codes and sink state encoding
package noc_flit_pkg;

  localparam int SRC_MSB = 19;
  localparam int SRC_LSB = 12;
  localparam int SEQ_MSB = 11;
  localparam int SEQ_LSB = 4;
  localparam int TAG_W   = 4;
  localparam int FLIT_W  = 20;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_SRC = 2'd1;
  localparam logic [1:0] ERR_SEQ     = 2'd2;
  localparam logic [1:0] ERR_EXTRA   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_TOUT = 2'd3
  } sink_state_t;

endpackage

// File: rtl/flit_sink_checker_if.sv
// rtl/flit_sink_checker_if.sv - flit ejection stream from a router local port into the sink
interface flit_sink_checker_if;
  import noc_flit_pkg::*;

  logic [FLIT_W-1:0] datain;
  logic              in_valid;

  modport master (output datain, output in_valid);
  modport slave  (input datain, input in_valid);
endinterface

// File: rtl/sink_src_table.sv
// rtl/sink_src_table.sv - per-source expected sequence and flit count with all-complete reduction
module sink_src_table
  import noc_flit_pkg::*;
#(
  parameter int NUM_SRC     = 16,
  parameter int EXP_PER_SRC = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [NUM_SRC-1:0] mask_in,
  input  logic               lookup,
  input  logic [7:0]         src,
  input  logic [7:0]         seq,
  output logic [1:0]         err_class,
  output logic               all_complete_next
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = $clog2(EXP_PER_SRC + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(EXP_PER_SRC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXP_PER_SRC - 1);

  logic [NUM_SRC-1:0] mask;
  logic [7:0]         exp_seq [NUM_SRC];
  logic [CNT_W-1:0]   count   [NUM_SRC];
  logic               in_range;
  logic [IDX_W-1:0]   idx;
  logic               upd;

  assign in_range = (int'(src) < NUM_SRC);
  assign idx      = src[IDX_W-1:0];

  always_comb begin
    err_class = ERR_NONE;
    if (!in_range || !mask[idx])
      err_class = ERR_BAD_SRC;
    else if (count[idx] == CNT_FULL)
      err_class = ERR_EXTRA;
    else if (seq != exp_seq[idx])
      err_class = ERR_SEQ;
  end

  // A sequence mismatch still consumes a slot and resyncs to the received number
  assign upd = lookup && ((err_class == ERR_NONE) || (err_class == ERR_SEQ));

  always_comb begin
    all_complete_next = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (mask[i] && (count[i] != CNT_FULL) &&
          !(upd && (idx == IDX_W'(i)) && (count[i] == CNT_LAST)))
        all_complete_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        exp_seq[i] <= 8'd1;
        count[i]   <= '0;
      end
    end else if (load) begin
      mask <= mask_in;
      for (int i = 0; i < NUM_SRC; i++) begin
        exp_seq[i] <= 8'd1;
        count[i]   <= '0;
      end
    end else if (upd) begin
      count[idx]   <= count[idx] + CNT_W'(1);
      exp_seq[idx] <= seq + 8'd1;
    end
  end

endmodule

// File: rtl/flit_sink_checker.sv
// rtl/flit_sink_checker.sv - NoC ejection-port sink: sequence checking, counters and pass/fail verdict
module flit_sink_checker
  import noc_flit_pkg::*;
#(
  parameter int NUM_SRC     = 16,
  parameter int EXP_PER_SRC = 30,
  parameter int TIMEOUT     = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [NUM_SRC-1:0]  src_mask,
  flit_sink_checker_if.slave  flit,
  output logic [15:0]         rx_count,
  output logic [15:0]         err_count,
  output logic [FLIT_W-1:0]   last_err,
  output logic [1:0]          err_code,
  output logic                busy,
  output logic                done,
  output logic                pass
);

  localparam int TIMER_W = $clog2(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  sink_state_t        state, next_state;
  logic [TIMER_W-1:0] timer;
  logic               tbl_load;
  logic               tbl_lookup;
  logic [1:0]         tbl_class;
  logic               all_complete_next;
  logic               flit_err;
  logic [1:0]         flit_code;

  sink_src_table #(
    .NUM_SRC     (NUM_SRC),
    .EXP_PER_SRC (EXP_PER_SRC)
  ) u_table (
    .clk               (clk),
    .rst               (rst),
    .load              (tbl_load),
    .mask_in           (src_mask),
    .lookup            (tbl_lookup),
    .src               (flit.datain[SRC_MSB:SRC_LSB]),
    .seq               (flit.datain[SEQ_MSB:SEQ_LSB]),
    .err_class         (tbl_class),
    .all_complete_next (all_complete_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    tbl_load   = 1'b0;
    tbl_lookup = 1'b0;
    flit_err   = 1'b0;
    flit_code  = ERR_NONE;
    unique case (state)
      ST_IDLE: begin
        if (enable) begin
          next_state = ST_RUN;
          tbl_load   = 1'b1;
        end
      end
      ST_RUN: begin
        tbl_lookup = flit.in_valid;
        if (flit.in_valid && (tbl_class != ERR_NONE)) begin
          flit_err  = 1'b1;
          flit_code = tbl_class;
        end
        // Completion is checked first so it wins over a coincident timeout
        if (all_complete_next)
          next_state = ST_DONE;
        else if (!flit.in_valid && (timer == TIMER_LAST))
          next_state = ST_TOUT;
      end
      default: begin
        if (flit.in_valid) begin
          flit_err  = 1'b1;
          flit_code = ERR_EXTRA;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_count  <= '0;
      err_count <= '0;
      last_err  <= '0;
      err_code  <= ERR_NONE;
      timer     <= '0;
      pass      <= 1'b0;
    end else begin
      if (tbl_load) begin
        rx_count  <= '0;
        err_count <= '0;
        last_err  <= '0;
        err_code  <= ERR_NONE;
        timer     <= '0;
        pass      <= 1'b0;
      end
      if (state == ST_RUN) begin
        if (flit.in_valid) begin
          if (rx_count != 16'hFFFF) rx_count <= rx_count + 16'd1;
          timer <= '0;
        end else begin
          timer <= timer + TIMER_W'(1);
        end
      end
      if (flit_err) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        last_err <= flit.datain;
        err_code <= flit_code;
      end
      if ((state == ST_RUN) && (next_state == ST_DONE))
        pass <= (err_count == 16'd0) && !flit_err;
      else if ((state == ST_DONE) && flit.in_valid)
        pass <= 1'b0;
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE) || (state == ST_TOUT);

endmodule

// File: tb/tb_flit_sink_checker.sv
// tb/tb_flit_sink_checker.sv - scenario tasks plus randomized traffic against a behavioural sink model
module tb_flit_sink_checker;
  import noc_flit_pkg::*;

  localparam int NS  = 16;
  localparam int EXP = 30;
  localparam int TMO = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] src_mask = '0;
  logic [15:0] rx_count, err_count;
  logic [19:0] last_err;
  logic [1:0]  err_code;
  logic        busy, done, pass;

  flit_sink_checker_if flit_bus ();

  flit_sink_checker #(.NUM_SRC(NS), .EXP_PER_SRC(EXP), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .src_mask  (src_mask),
    .flit      (flit_bus),
    .rx_count  (rx_count),
    .err_count (err_count),
    .last_err  (last_err),
    .err_code  (err_code),
    .busy      (busy),
    .done      (done),
    .pass      (pass)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: phase 0 idle, 1 running, 2 finished, 3 timed out
  int          m_phase;
  bit [15:0]   m_mask;
  int          m_exp [NS];
  int          m_cnt [NS];
  int          m_rx, m_err, m_code, m_idle;
  bit [19:0]   m_last;
  bit          m_pass;

  task automatic model_clear();
    m_phase = 0; m_mask = '0; m_rx = 0; m_err = 0; m_code = 0;
    m_idle = 0; m_last = '0; m_pass = 1'b0;
    for (int i = 0; i < NS; i++) begin m_exp[i] = 1; m_cnt[i] = 0; end
  endtask

  task automatic model_error(int code, bit [19:0] d);
    if (m_err < 65535) m_err++;
    m_code = code;
    m_last = d;
  endtask

  task automatic model_cycle(bit en, bit [15:0] mask, bit v, bit [19:0] d);
    int  s, q;
    bit  all;
    s = int'(d[19:12]);
    q = int'(d[11:4]);
    if (m_phase == 0) begin
      if (en) begin
        model_clear();
        m_phase = 1;
        m_mask  = mask;
      end
    end else if (m_phase == 1) begin
      if (v) begin
        if (m_rx < 65535) m_rx++;
        m_idle = 0;
        if (s >= NS || !m_mask[s]) model_error(1, d);
        else if (m_cnt[s] == EXP) model_error(3, d);
        else begin
          if (q != m_exp[s]) model_error(2, d);
          m_cnt[s]++;
          m_exp[s] = (q + 1) % 256;
        end
      end else begin
        m_idle++;
      end
      all = 1'b1;
      for (int i = 0; i < NS; i++)
        if (m_mask[i] && m_cnt[i] != EXP) all = 1'b0;
      if (all) begin
        m_phase = 2;
        m_pass  = (m_err == 0);
      end else if (m_idle == TMO) begin
        m_phase = 3;
        m_pass  = 1'b0;
      end
    end else if (v) begin
      model_error(3, d);
      if (m_phase == 2) m_pass = 1'b0;
    end
  endtask

  function automatic logic [19:0] mk(int s, int q, int t);
    return {8'(s), 8'(q), 4'(t)};
  endfunction

  task automatic step(bit en, bit [15:0] mask, bit v, bit [19:0] d);
    enable = en;
    src_mask = mask;
    flit_bus.in_valid = v;
    flit_bus.datain = d;
    @(posedge clk);
    #1;
    model_cycle(en, mask, v, d);
    flit_bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    flit_bus.in_valid = 1'b0;
    flit_bus.datain = '0;
    @(posedge clk);
    #3 rst = 1'b0;
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
  endtask

  task automatic test_reset();
    flit_bus.in_valid = 1'b0;
    flit_bus.datain = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_clear();
    checks++;
    if ({rx_count, err_count, last_err, err_code, busy, done, pass} !== 59'd0) begin
      failures++;
      $display("FAIL reset_state: got rx=%0d err=%0d last=%h code=%0d busy=%b done=%b pass=%b, want all 0",
               rx_count, err_count, last_err, err_code, busy, done, pass);
    end
  endtask

  task automatic test_clean_run();
    do_reset();
    step(1'b1, 16'h0008, 1'b1, 20'h03010);
    checks++;
    if (busy !== 1'b1 || rx_count !== 16'd0) begin
      failures++;
      $display("FAIL start_flit_ignored: got busy=%b rx=%0d, want busy=1 rx=0", busy, rx_count);
    end
    for (int k = 1; k <= 30; k++) begin
      step(1'b0, 16'h0008, 1'b1, mk(3, k, $urandom_range(0, 15)));
      if (k == 29) begin
        checks++;
        if (done !== 1'b0) begin
          failures++;
          $display("FAIL early_done: got done=%b after 29 flits, want 0", done);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || rx_count !== 16'd30 || err_count !== 16'd0) begin
      failures++;
      $display("FAIL clean_run: got done=%b pass=%b rx=%0d err=%0d, want 1 1 30 0",
               done, pass, rx_count, err_count);
    end
  endtask

  task automatic test_extra();
    step(1'b0, 16'h0008, 1'b1, 20'h03200);
    checks++;
    if (err_count !== 16'd1 || err_code !== ERR_EXTRA || pass !== 1'b0 ||
        rx_count !== 16'd30 || last_err !== 20'h03200 || done !== 1'b1) begin
      failures++;
      $display("FAIL extra_flit: got err=%0d code=%0d pass=%b rx=%0d last=%h done=%b, want 1 3 0 30 03200 1",
               err_count, err_code, pass, rx_count, last_err, done);
    end
  endtask

  task automatic test_dup_seq();
    int seqs[$];
    do_reset();
    step(1'b1, 16'h0008, 1'b0, '0);
    for (int k = 1; k <= 5; k++) seqs.push_back(k);
    for (int k = 5; k <= 30; k++) seqs.push_back(k);
    foreach (seqs[j]) begin
      step(1'b0, 16'h0008, 1'b1, mk(3, seqs[j], 0));
      if (j == 5) begin
        checks++;
        if (err_code !== ERR_SEQ || last_err !== 20'h03050 || err_count !== 16'd1) begin
          failures++;
          $display("FAIL dup_seq: got code=%0d last=%h err=%0d, want 2 03050 1",
                   err_code, last_err, err_count);
        end
      end
      if (j == 6) begin
        checks++;
        if (err_count !== 16'd1) begin
          failures++;
          $display("FAIL resync: got err=%0d after seq 6, want 1", err_count);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || pass !== 1'b0 || rx_count !== 16'd30 || err_count !== 16'd2 ||
        err_code !== ERR_EXTRA) begin
      failures++;
      $display("FAIL dup_verdict: got done=%b pass=%b rx=%0d err=%0d code=%0d, want 1 0 30 2 3",
               done, pass, rx_count, err_count, err_code);
    end
  endtask

  task automatic test_bad_src();
    do_reset();
    step(1'b1, 16'h0008, 1'b0, '0);
    step(1'b0, 16'h0008, 1'b1, 20'h12010);
    checks++;
    if (err_code !== ERR_BAD_SRC || err_count !== 16'd1 || rx_count !== 16'd1 || last_err !== 20'h12010) begin
      failures++;
      $display("FAIL bad_src_range: got code=%0d err=%0d rx=%0d last=%h, want 1 1 1 12010",
               err_code, err_count, rx_count, last_err);
    end
    step(1'b0, 16'h0008, 1'b1, 20'h05010);
    checks++;
    if (err_code !== ERR_BAD_SRC || err_count !== 16'd2 || rx_count !== 16'd2) begin
      failures++;
      $display("FAIL bad_src_masked: got code=%0d err=%0d rx=%0d, want 1 2 2", err_code, err_count, rx_count);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    step(1'b1, 16'h0003, 1'b0, '0);
    for (int k = 1; k <= 30; k++) step(1'b0, 16'h0003, 1'b1, mk(0, k, 0));
    for (int k = 0; k < TMO - 1; k++) step(1'b0, 16'h0003, 1'b0, '0);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_early: got done=%b busy=%b after 1023 idle, want 0 1", done, busy);
    end
    step(1'b0, 16'h0003, 1'b0, '0);
    checks++;
    if (done !== 1'b1 || pass !== 1'b0 || busy !== 1'b0 || rx_count !== 16'd30) begin
      failures++;
      $display("FAIL timeout: got done=%b pass=%b busy=%b rx=%0d, want 1 0 0 30", done, pass, busy, rx_count);
    end
    step(1'b1, 16'h0003, 1'b0, '0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL tout_terminal: got done=%b busy=%b, want 1 0", done, busy);
    end
  endtask

  task automatic test_zero_mask();
    do_reset();
    step(1'b1, 16'h0000, 1'b0, '0);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL zero_mask_run: got busy=%b done=%b, want 1 0", busy, done);
    end
    step(1'b0, 16'h0000, 1'b0, '0);
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_mask_done: got done=%b pass=%b busy=%b, want 1 1 0", done, pass, busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b1, 16'h0008, 1'b0, '0);
    for (int k = 1; k <= 10; k++) step(1'b0, 16'h0008, 1'b1, mk(3, k == 4 ? 9 : k, 0));
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({rx_count, err_count, last_err, err_code, busy, done, pass} !== 59'd0) begin
      failures++;
      $display("FAIL reset_mid: got rx=%0d err=%0d last=%h code=%0d busy=%b done=%b pass=%b, want all 0",
               rx_count, err_count, last_err, err_code, busy, done, pass);
    end
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
    step(1'b1, 16'h0008, 1'b0, '0);
    for (int k = 1; k <= 30; k++) step(1'b0, 16'h0008, 1'b1, mk(3, k, 0));
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || rx_count !== 16'd30 || err_count !== 16'd0) begin
      failures++;
      $display("FAIL rerun_after_reset: got done=%b pass=%b rx=%0d err=%0d, want 1 1 30 0",
               done, pass, rx_count, err_count);
    end
  endtask

  task automatic test_random();
    bit [15:0] mask;
    bit [19:0] d;
    bit        v, en;
    int        r, s, q, tail;
    for (int iter = 0; iter < 6; iter++) begin
      do_reset();
      mask = (iter == 0) ? 16'hFFFF : 16'($urandom);
      step(1'b1, mask, 1'($urandom_range(0, 1)), 20'($urandom));
      tail = 0;
      for (int cyc = 0; cyc < 2000 && tail < 6; cyc++) begin
        r = $urandom_range(0, 99);
        en = 1'($urandom_range(0, 1));
        v = 1'b1;
        s = $urandom_range(0, 15);
        q = $urandom_range(0, 255);
        if (r < 15) v = 1'b0;
        else if (r < 20) s = $urandom_range(16, 255);
        else if (r >= 25) begin
          int start = $urandom_range(0, NS - 1);
          for (int j = 0; j < NS; j++) begin
            int i = (start + j) % NS;
            if (m_mask[i] && m_cnt[i] < EXP) begin s = i; break; end
          end
          q = ($urandom_range(0, 99) < 5) ? $urandom_range(0, 255) : m_exp[s];
        end
        d = mk(s, q, $urandom_range(0, 15));
        step(en, mask, v, d);
        if (m_phase >= 2) tail++;
        checks++;
        if ({rx_count, err_count, last_err, err_code, busy, done, pass} !==
            {16'(m_rx), 16'(m_err), m_last, 2'(m_code), 1'(m_phase == 1), 1'(m_phase >= 2), m_pass}) begin
          failures++;
          $display("FAIL random_it%0d_cyc%0d: got rx=%0d err=%0d last=%h code=%0d busy=%b done=%b pass=%b, want rx=%0d err=%0d last=%h code=%0d phase=%0d pass=%b",
                   iter, cyc, rx_count, err_count, last_err, err_code, busy, done, pass,
                   m_rx, m_err, m_last, m_code, m_phase, m_pass);
        end
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_clean_run();
    test_extra();
    test_dup_seq();
    test_bad_src();
    test_timeout();
    test_zero_mask();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flit_sink_checker.md
# flit_sink_checker

Destination-side traffic sink for the NoC test harness: consumes the 20-bit flit stream delivered at a local ejection port and checks it against the one-shot injection pattern produced by the source-side dataout buffers. It tracks per-source sequence numbers and completion, counts received and erroneous flits, and reports a sticky pass/fail verdict with a timeout. One instance sits on each router's local output port. Status outputs feed the top-level testbench and the on-board status LEDs/ILA.

## Interface
- NUM_SRC, 16: number of source IDs tracked; valid IDs are 0..NUM_SRC-1.
- EXP_PER_SRC, 30: flits expected from each enabled source.
- TIMEOUT, 1024: idle cycles in RUN, with no accepted flit, before a timeout verdict.
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- enable  in  1  start request; sampled only in IDLE.
- src_mask  in  NUM_SRC  bit i set means source i is expected; captured on the IDLE→RUN transition.
- datain  in  20  flit: [19:12] source ID, [11:4] sequence number (first flit = 1), [3:0] tag (ignored).
- in_valid  in  1  datain is valid this cycle. There is no backpressure: every valid flit is consumed.
- rx_count  out  16  flits accepted in RUN; saturates at 0xFFFF.
- err_count  out  16  erroneous flits; saturates at 0xFFFF.
- last_err  out  20  most recent erroneous flit.
- err_code  out  2  class of last error: 0 none, 1 bad source, 2 sequence mismatch, 3 extra flit.
- busy  out  1  state is RUN.
- done  out  1  sticky; verdict reached.
- pass  out  1  valid when done=1.

## Operation
- States: IDLE, RUN, DONE, TOUT.
- IDLE:
  - in_valid is ignored.
  - enable=1 moves to RUN. On that transition: capture src_mask, set every expected_seq[i]=1, clear every per-source count[i], clear rx_count, err_count, last_err, err_code and the idle timer.
- RUN, on an accepted flit (in_valid=1):
  - rx_count increments.
  - Let s=datain[19:12] and q=datain[11:4].
  - If s≥NUM_SRC or mask[s]=0: bad source (code 1).
  - Else if count[s]==EXP_PER_SRC: extra flit (code 3).
  - Else if q≠expected_seq[s]: sequence mismatch (code 2). Then count[s]++ and expected_seq[s]=q+1, i.e. resync.
  - Else: the flit is good. count[s]++ and expected_seq[s]++.
  - expected_seq is 8 bits and wraps 0xFF→0x00.
  - Every error increments err_count and loads last_err=datain and err_code.
- Completion:
  - Source i is complete when mask[i]=0 or count[i]==EXP_PER_SRC.
  - When all sources are complete: RUN→DONE with pass=(err_count==0).
  - The check uses post-update values, including the flit just accepted.
- Timeout:
  - The idle timer resets on each accepted flit and otherwise increments in RUN.
  - Reaching TIMEOUT moves RUN→TOUT with pass=0.
  - If completion and timeout occur in the same cycle, DONE wins.
- DONE and TOUT:
  - Terminal until reset; enable is ignored.
  - Flits arriving here still increment err_count as code 3 (extra), and pass is recomputed as 0 in DONE. rx_count is frozen.
- enable is ignored outside IDLE; deasserting it in RUN has no effect.
- If src_mask is all-zero at start, the next cycle goes RUN→DONE with pass=1.

## Timing
- Reset values: rx_count=0, err_count=0, last_err=0, err_code=0, busy=0, done=0, pass=0, state IDLE.
- Reset acts immediately, including mid-RUN. All tracking is lost.
- IDLE→RUN takes 1 cycle after the enable edge is sampled. A flit on that same sampling cycle is ignored.
- Flit-to-counter latency is 1 cycle: counters reflect the flit on the next edge.
- done, and pass in DONE, assert on the same edge as the counter update caused by the completing flit.
- TOUT is entered on the edge where the timer reaches TIMEOUT, which is TIMEOUT cycles after the last accepted flit.
- One flit per cycle is sustained indefinitely; back-to-back in_valid is supported.

## Structure
- Shared package `noc_flit_pkg`:
  - flit field constants: SRC_MSB=19, SRC_LSB=12, SEQ_MSB=11, SEQ_LSB=4, TAG width 4, FLIT_W=20;
  - err_code constants;
  - sink state encoding.
- Sub-module `sink_src_table`:
  - holds the NUM_SRC×(8-bit expected_seq, count) registers;
  - takes one lookup/update per cycle;
  - provides the all-complete reduction.
- The top level holds the FSM, the timer and the saturating counters.

## Test plan
- Mask 0x0008, source 3 sends 0x03010..0x031E0 (seq 1..30) back-to-back → done=1, pass=1, rx_count=30, err_count=0 on the edge after the 30th flit.
- Same stream with seq 5 duplicated (0x03050 sent twice) → err_code=2, last_err=0x03050, err_count=1; expected resyncs to 6; done then pass=0.
- Flit 0x12010 (source 0x12≥16) during RUN → err_code=1, err_count=1, rx_count=1.
- Mask 0x0003, only source 0 completes and source 1 is silent → TOUT after exactly 1024 idle cycles, done=1, pass=0.
- 31st flit 0x03200 after completion → err_count=1, err_code=3, pass drops to 0; rx_count stays 30.
- Reset asserted mid-stream → all outputs read 0 at once; after re-enable, a fresh 30-flit run passes.
